// File: rtl/xnor_window_streamer_if.sv
// Load/stream handshake bundle for the XNOR window streamer.
// master drives jobs and loads, slave is the streamer itself.
interface xnor_window_streamer_if #(
  parameter int C  = 18,
  parameter int PW = 6
) ();
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [C-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [C-1:0]  out_xnor;
  logic          out_sop;
  logic          out_eop;
  logic [PW-1:0] out_pos;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_xnor,
    input  out_sop, out_eop, out_pos, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_xnor,
    output out_sop, out_eop, out_pos, busy, done
  );
endinterface

// File: rtl/xnor_window_streamer.sv
// Loads a binarized fmap and kernel, then streams per-tap XNOR
// products window by window for a downstream popcount accumulator.
module xnor_window_streamer #(
  parameter int C = 18,
  parameter int H = 12,
  parameter int K = 5
) (
  input logic clk,
  input logic rst_n,
  xnor_window_streamer_if.slave bus
);

  localparam int OH   = H - K + 1;
  localparam int NPIX = H * H;
  localparam int NTAP = K * K;
  localparam int LW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int OW   = (OH > 1) ? $clog2(OH) : 1;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int PW   = (OH * OH > 1) ? $clog2(OH * OH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_FMAP,
    LOAD_KERN,
    STREAM
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LW-1:0] ld_q;
  logic [OW-1:0] oy_q;
  logic [OW-1:0] ox_q;
  logic [KW-1:0] ky_q;
  logic [KW-1:0] kx_q;

  logic [C-1:0] pix  [NPIX];
  logic [C-1:0] kern [NTAP];

  logic          in_phase;
  logic          in_fire;
  logic          out_fire;
  logic          ld_last_f;
  logic          ld_last_k;
  logic          ld_wrap;
  logic          kx_last;
  logic          ky_last;
  logic          ox_last;
  logic          oy_last;
  logic          beat_last;
  logic [LW-1:0] row;
  logic [LW-1:0] col;
  logic [LW-1:0] paddr;
  logic [TW-1:0] kaddr;
  logic [PW-1:0] pos;

  // handshake qualifiers derive from state only, never from own outputs
  assign in_phase  = (state_q == LOAD_FMAP) || (state_q == LOAD_KERN);
  assign in_fire   = in_phase && bus.in_valid;
  assign out_fire  = (state_q == STREAM) && bus.out_ready;

  assign ld_last_f = (ld_q == LW'(NPIX - 1));
  assign ld_last_k = (ld_q == LW'(NTAP - 1));
  assign ld_wrap   = ((state_q == LOAD_FMAP) && ld_last_f)
                  || ((state_q == LOAD_KERN) && ld_last_k);

  assign kx_last   = (kx_q == KW'(K - 1));
  assign ky_last   = (ky_q == KW'(K - 1));
  assign ox_last   = (ox_q == OW'(OH - 1));
  assign oy_last   = (oy_q == OW'(OH - 1));
  assign beat_last = kx_last && ky_last && ox_last && oy_last;

  assign row   = LW'(oy_q) + LW'(ky_q);
  assign col   = LW'(ox_q) + LW'(kx_q);
  assign paddr = row * LW'(H) + col;
  assign kaddr = TW'(ky_q) * TW'(K) + TW'(kx_q);
  assign pos   = PW'(oy_q) * PW'(OH) + PW'(ox_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: each phase ends on the transfer of its final word/beat
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.start) state_d = LOAD_FMAP;
      LOAD_FMAP: if (in_fire && ld_last_f) state_d = LOAD_KERN;
      LOAD_KERN: if (in_fire && ld_last_k) state_d = STREAM;
      STREAM:    if (out_fire && beat_last) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // outputs: payload is a pure function of held counters, so it is
  // stable across any number of stalled cycles
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_xnor  = '0;
    bus.out_sop   = 1'b0;
    bus.out_eop   = 1'b0;
    bus.out_pos   = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      LOAD_FMAP, LOAD_KERN: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      STREAM: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_xnor  = ~(pix[paddr] ^ kern[kaddr]);
        bus.out_sop   = (ky_q == '0) && (kx_q == '0);
        bus.out_eop   = ky_last && kx_last;
        bus.out_pos   = pos;
        bus.done      = out_fire && beat_last;
      end
      default: begin
      end
    endcase
  end

  // load index and window counters; kx innermost, oy outermost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q <= '0;
      oy_q <= '0;
      ox_q <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else if (state_q == IDLE) begin
      ld_q <= '0;
      oy_q <= '0;
      ox_q <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else begin
      if (in_fire) begin
        ld_q <= ld_wrap ? '0 : ld_q + 1'b1;
      end
      if (out_fire) begin
        kx_q <= kx_last ? '0 : kx_q + 1'b1;
        if (kx_last) begin
          ky_q <= ky_last ? '0 : ky_q + 1'b1;
          if (ky_last) begin
            ox_q <= ox_last ? '0 : ox_q + 1'b1;
            if (ox_last) begin
              oy_q <= oy_last ? '0 : oy_q + 1'b1;
            end
          end
        end
      end
    end
  end

  // buffers hold no reset value; every job rewrites them fully
  always_ff @(posedge clk) begin
    if (in_fire && (state_q == LOAD_FMAP)) begin
      pix[ld_q] <= bus.in_data;
    end
    if (in_fire && (state_q == LOAD_KERN)) begin
      kern[TW'(ld_q)] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_xnor_window_streamer.sv
// Directed bench for xnor_window_streamer: load/stream jobs,
// back-pressure, load gaps, start-while-busy and mid-job reset.
module tb_xnor_window_streamer;

  localparam int C  = 18;
  localparam int H  = 12;
  localparam int K  = 5;
  localparam int OH = 8;
  localparam int NB = OH * OH * K * K;

  typedef struct {
    int          beat;
    logic [17:0] x;
    logic        sop;
    logic        eop;
    logic [5:0]  pos;
  } vec_t;

  logic clk;
  logic rst_n;

  xnor_window_streamer_if #(.C(C), .PW(6)) bus ();

  xnor_window_streamer #(.C(C), .H(H), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [C-1:0] bx [NB];
  logic         bs [NB];
  logic         be [NB];
  logic         bd [NB];
  logic [5:0]   bp [NB];
  int           nb;
  int           scyc;
  int           stall_err;
  int           novalid;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [C-1:0] pixv(int fm, int r, int c);
    logic [C-1:0] one;
    one = 1;
    if (fm == 0) return '1;
    return one << ((r + c) % C);
  endfunction

  function automatic logic [C-1:0] kernv(int km);
    return (km == 0) ? '1 : '0;
  endfunction

  function automatic logic [C-1:0] word(int idx, int fm, int km);
    if (idx < H * H) return pixv(fm, idx / H, idx % H);
    return kernv(km);
  endfunction

  task automatic do_load(input int fm, input int km, input bit gaps);
    int idx;
    int cyc;
    int bad;
    idx = 0;
    cyc = 0;
    bad = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (idx < H * H + K * K && cyc < 5000) begin
      bus.in_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
      bus.in_data  = word(idx, fm, km);
      @(negedge clk);
      cyc++;
      if (bus.out_valid) bad++;
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk("load_count", idx, H * H + K * K);
    chk("load_no_out_valid", bad, 0);
    @(negedge clk);
    chk("stream_entry", {bus.in_ready, bus.out_valid}, 2'b01);
  endtask

  task automatic do_stream(input bit rnd, input int nmax,
                           input int start_at);
    bit           pend;
    logic [C-1:0] hx;
    logic         hs;
    logic         he;
    logic [5:0]   hp;
    pend = 0;
    hx = '0;
    hs = 0;
    he = 0;
    hp = '0;
    nb = 0;
    scyc = 0;
    stall_err = 0;
    novalid = 0;
    while (nb < nmax && scyc < 20000) begin
      @(posedge clk); #1;
      bus.out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      bus.start = (start_at >= 0) && (nb == start_at);
      @(negedge clk);
      scyc++;
      if (!bus.out_valid) begin
        novalid++;
      end else begin
        if (pend && ({bus.out_xnor, bus.out_sop, bus.out_eop,
                      bus.out_pos} !== {hx, hs, he, hp}))
          stall_err++;
        if (bus.out_ready) begin
          bx[nb] = bus.out_xnor;
          bs[nb] = bus.out_sop;
          be[nb] = bus.out_eop;
          bp[nb] = bus.out_pos;
          bd[nb] = bus.done;
          nb++;
          pend = 0;
        end else begin
          if (bus.done) stall_err++;
          pend = 1;
          hx = bus.out_xnor;
          hs = bus.out_sop;
          he = bus.out_eop;
          hp = bus.out_pos;
        end
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    chk("beat_count", nb, nmax);
    chk("stall_stable", stall_err, 0);
    chk("valid_every_cycle", novalid, 0);
  endtask

  task automatic verify(input string tag, input int fm, input int km);
    int errs;
    int first;
    errs = 0;
    first = -1;
    for (int i = 0; i < nb; i++) begin
      int p;
      int t;
      int oy;
      int ox;
      int ky;
      int kx;
      logic [C-1:0] ex;
      p  = i / (K * K);
      t  = i % (K * K);
      oy = p / OH;
      ox = p % OH;
      ky = t / K;
      kx = t % K;
      ex = ~(pixv(fm, oy + ky, ox + kx) ^ kernv(km));
      if (bx[i] !== ex || bs[i] !== (t == 0) || be[i] !== (t == K * K - 1)
          || bp[i] !== 6'(p) || bd[i] !== (i == NB - 1)) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    if (errs != 0)
      $display("first bad beat %0d in %s", first, tag);
    chk(tag, errs, 0);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      int b;
      b = vt[i].beat;
      chk($sformatf("%s_vec%0d_beat%0d", tag, i, b),
          {bx[b], bs[b], be[b], bp[b]},
          {vt[i].x, vt[i].sop, vt[i].eop, vt[i].pos});
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk(tag, {bus.out_valid, bus.busy, bus.done, bus.in_ready}, 4'b0000);
  endtask

  initial begin
    vt[0] = '{0,    18'h3fffe, 1'b1, 1'b0, 6'd0};
    vt[1] = '{7,    18'h3fff7, 1'b0, 1'b0, 6'd0};
    vt[2] = '{24,   18'h3feff, 1'b0, 1'b1, 6'd0};
    vt[3] = '{25,   18'h3fffd, 1'b1, 1'b0, 6'd1};
    vt[4] = '{200,  18'h3fffd, 1'b1, 1'b0, 6'd8};
    vt[5] = '{599,  18'h1ffff, 1'b0, 1'b1, 6'd23};
    vt[6] = '{1000, 18'h3ffdf, 1'b1, 1'b0, 6'd40};
    vt[7] = '{1012, 18'h3fdff, 1'b0, 1'b0, 6'd40};
    vt[8] = '{1575, 18'h3bfff, 1'b1, 1'b0, 6'd63};
    vt[9] = '{1599, 18'h3ffef, 1'b0, 1'b1, 6'd63};

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("reset_outputs",
        {bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop,
         bus.busy, bus.done},
        6'b0);
    chk("reset_payload", {bus.out_xnor, bus.out_pos}, '0);
    #20;
    rst_n = 1'b1;

    do_load(0, 0, 1'b0);
    do_stream(1'b0, NB, -1);
    chk("j1_throughput_cycles", scyc, NB);
    verify("j1_all_ones", 0, 0);
    check_idle("j1_idle_after");

    do_load(1, 1, 1'b0);
    do_stream(1'b0, NB, -1);
    verify("j2_onehot", 1, 1);
    check_table("j2");
    check_idle("j2_idle_after");

    do_load(1, 1, 1'b1);
    do_stream(1'b1, NB, -1);
    verify("j3_backpressure_gaps", 1, 1);
    check_table("j3");
    check_idle("j3_idle_after");

    do_load(1, 1, 1'b0);
    do_stream(1'b0, 700, 100);
    for (int i = 0; i < nb; i++) bd[i] = (i == NB - 1);
    verify("j4_start_ignored", 1, 1);
    bus.out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midjob_reset_outputs",
        {bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop,
         bus.busy, bus.done},
        6'b0);
    chk("midjob_reset_payload", {bus.out_xnor, bus.out_pos}, '0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_load(0, 1, 1'b0);
    do_stream(1'b0, NB, -1);
    chk("j5_throughput_cycles", scyc, NB);
    verify("j5_after_reset", 0, 1);
    check_idle("j5_idle_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
